// File: rtl/shift_pkg.sv
// Shared types and constants for the multi-cycle shift controller.
package shift_pkg;

   localparam int DATA_W  = 32;
   localparam int SHAMT_W = 5;

   typedef enum logic [1:0] {
      SHIFT_SLL = 2'b00,
      SHIFT_SRL = 2'b01,
      SHIFT_SRA = 2'b10,
      SHIFT_RSV = 2'b11
   } shift_op_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_DONE  = 2'b10
   } state_e;

endpackage

// File: rtl/shift_step.sv
// One-bit shift of a 32-bit word, selected by shift op.
module shift_step
   import shift_pkg::*;
(
   input  logic [DATA_W-1:0] din_i,
   input  shift_op_e         op_i,
   output logic [DATA_W-1:0] dout_o
);

   always_comb begin
      dout_o = din_i;
      case (op_i)
         SHIFT_SLL: dout_o = {din_i[DATA_W-2:0], 1'b0};
         SHIFT_SRL: dout_o = {1'b0, din_i[DATA_W-1:1]};
         SHIFT_SRA: dout_o = {din_i[DATA_W-1], din_i[DATA_W-1:1]};
         default:   dout_o = din_i;
      endcase
   end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift controller: shifts one bit position per clock until the
// captured shift amount is exhausted, then pulses done with the result.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for start; result holds the last value
// ST_SHIFT | one bit step per cycle, cnt counts remaining steps
// ST_DONE  | done pulse, result valid; accepts a back-to-back start
module shift_seq_ctrl
   import shift_pkg::*;
(
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic [1:0]         op,
   input  logic [DATA_W-1:0]  data_in,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [DATA_W-1:0]  result
);

   state_e             state_q, state_d;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   shift_op_e          op_q, op_d;
   logic [DATA_W-1:0]  shreg_q, shreg_d;
   logic               err_q, err_d;
   logic [DATA_W-1:0]  step_out;

   shift_step u_step (
      .din_i  (shreg_q),
      .op_i   (op_q),
      .dout_o (step_out)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         op_q    <= SHIFT_SLL;
         shreg_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         shreg_q <= shreg_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      shreg_d = shreg_q;
      err_d   = 1'b0;
      case (state_q)
         ST_SHIFT: begin
            shreg_d = step_out;
            cnt_d   = cnt_q - 5'd1;
            if (cnt_q == 5'd1) state_d = ST_DONE;
         end
         // IDLE, DONE and the unused encoding all behave as accepting states
         default: begin
            state_d = ST_IDLE;
            if (start) begin
               if (shift_op_e'(op) == SHIFT_RSV) begin
                  err_d = 1'b1;
               end else begin
                  shreg_d = data_in;
                  cnt_d   = shamt;
                  op_d    = shift_op_e'(op);
                  state_d = (shamt != '0) ? ST_SHIFT : ST_DONE;
               end
            end
         end
      endcase
   end

   assign busy   = (state_q == ST_SHIFT);
   assign done   = (state_q == ST_DONE);
   assign err    = err_q;
   assign result = shreg_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Self-checking bench for shift_seq_ctrl: behavioural model plus directed cases.
module tb_shift_seq_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] data_in;
   logic [4:0]  shamt;
   logic        busy, done, err;
   logic [31:0] result;

   int tests = 0;
   int fails = 0;

   // model state: remaining shift cycles, expected flags, final result
   logic        m_busy, m_done, m_err, m_valid;
   int          m_rem;
   logic [31:0] m_res;

   shift_seq_ctrl dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .op      (op),
      .data_in (data_in),
      .shamt   (shamt),
      .busy    (busy),
      .done    (done),
      .err     (err),
      .result  (result)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_shift(input logic [1:0] o, input logic [31:0] d,
                                             input logic [4:0] sh);
      logic [31:0] r;
      case (o)
         2'd0:    r = d << sh;
         2'd1:    r = d >> sh;
         default: r = $signed(d) >>> sh;
      endcase
      return r;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_done = 0; m_err = 0; m_valid = 1; m_rem = 0; m_res = '0;
   endtask

   task automatic model_update(input logic s, input logic [1:0] o, input logic [31:0] d,
                               input logic [4:0] sh);
      m_done = 0;
      m_err  = 0;
      if (m_busy) begin
         m_rem--;
         if (m_rem == 0) begin
            m_busy  = 0;
            m_done  = 1;
            m_valid = 1;
         end
      end else if (s) begin
         if (o == 2'd3) begin
            m_err = 1;
         end else begin
            m_res = ref_shift(o, d, sh);
            if (sh == 0) begin
               m_done  = 1;
               m_valid = 1;
            end else begin
               m_busy  = 1;
               m_rem   = sh;
               m_valid = 0;
            end
         end
      end
   endtask

   task automatic compare();
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("err",  {31'd0, err},  {31'd0, m_err});
      if (m_valid) chk("result", result, m_res);
   endtask

   // called at a negedge; drives inputs, advances one clock, checks at next negedge
   task automatic step_cyc(input logic s, input logic [1:0] o, input logic [31:0] d,
                           input logic [4:0] sh);
      start = s; op = o; data_in = d; shamt = sh;
      @(posedge clk);
      model_update(s, o, d, sh);
      @(negedge clk);
      start = 0;
      compare();
   endtask

   task automatic directed(input logic [1:0] o, input logic [31:0] d, input logic [4:0] sh,
                           input logic [31:0] exp_res, input int exp_lat);
      int lat;
      int bcnt;
      step_cyc(1'b1, o, d, sh);
      lat  = 1;
      bcnt = busy ? 1 : 0;
      while (!done && lat < 40) begin
         step_cyc(1'b0, 2'd0, 32'd0, 5'd0);
         lat++;
         if (busy) bcnt++;
      end
      chk("latency", lat, exp_lat);
      chk("busy_cycles", bcnt, exp_lat - 1);
      chk("lit_result", result, exp_res);
   endtask

   initial begin
      reset_n = 0; start = 0; op = 0; data_in = 0; shamt = 0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      compare();
      chk("rst_result", result, 32'h0);
      reset_n = 1;
      step_cyc(1'b0, 2'd0, 32'd0, 5'd0);

      directed(2'd0, 32'h0000_0001, 5'd4,  32'h0000_0010, 5);
      directed(2'd2, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 32);
      directed(2'd1, 32'h8000_0000, 5'd31, 32'h0000_0001, 32);
      step_cyc(1'b0, 2'd0, 32'd0, 5'd0);
      directed(2'd1, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1);
      step_cyc(1'b0, 2'd0, 32'd0, 5'd0);

      // reserved op in IDLE: err pulse only, result untouched
      step_cyc(1'b1, 2'd3, 32'h1234_5678, 5'd3);
      chk("err_pulse", {31'd0, err}, 32'd1);
      chk("err_result", result, 32'hDEAD_BEEF);
      step_cyc(1'b0, 2'd0, 32'd0, 5'd0);
      chk("err_clear", {31'd0, err}, 32'd0);

      // start during SHIFT is ignored
      step_cyc(1'b1, 2'd0, 32'h0000_0001, 5'd3);
      step_cyc(1'b1, 2'd1, 32'h0000_FFFF, 5'd0);
      step_cyc(1'b0, 2'd0, 32'd0, 5'd0);
      step_cyc(1'b0, 2'd0, 32'd0, 5'd0);
      chk("ign_done", {31'd0, done}, 32'd1);
      chk("ign_result", result, 32'h0000_0008);
      step_cyc(1'b0, 2'd0, 32'd0, 5'd0);

      // back-to-back from the DONE cycle
      step_cyc(1'b1, 2'd0, 32'h3, 5'd1);
      step_cyc(1'b0, 2'd0, 32'd0, 5'd0);
      chk("b2b_done1", {31'd0, done}, 32'd1);
      chk("b2b_res1", result, 32'h6);
      step_cyc(1'b1, 2'd0, 32'h3, 5'd2);
      step_cyc(1'b0, 2'd0, 32'd0, 5'd0);
      step_cyc(1'b0, 2'd0, 32'd0, 5'd0);
      chk("b2b_done2", {31'd0, done}, 32'd1);
      chk("b2b_res2", result, 32'hC);

      // reset in the middle of a long shift
      step_cyc(1'b1, 2'd0, 32'h0000_00FF, 5'd20);
      repeat (5) step_cyc(1'b0, 2'd0, 32'd0, 5'd0);
      reset_n = 0;
      #1;
      model_reset();
      compare();
      chk("mid_rst_result", result, 32'h0);
      @(negedge clk);
      compare();
      reset_n = 1;
      step_cyc(1'b0, 2'd0, 32'd0, 5'd0);
      directed(2'd0, 32'h0000_00FF, 5'd20, 32'h0FF0_0000, 21);

      // randomized traffic, including reserved ops and starts in DONE/SHIFT
      for (int i = 0; i < 400; i++) begin
         logic       s;
         logic [4:0] sh;
         s  = ($urandom_range(0, 2) == 0);
         sh = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31))
                                          : 5'($urandom_range(0, 6));
         step_cyc(s, 2'($urandom_range(0, 3)), $urandom, sh);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
